// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, grant encoding, latency counter width.
package mem_arb_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_t;
    typedef enum logic {GNT_CPU, GNT_EXT} grant_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way pick between CPU (req[0]) and external port (req[1]).
// Build option: MEMARB_CPU_PRIO_EN selects fixed CPU priority instead of round-robin.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last,
    output grant_t     gnt
);

    always_comb begin
        gnt = GNT_CPU;
`ifdef MEMARB_CPU_PRIO_EN
        if (!req[0] && req[1]) gnt = GNT_EXT;
`else
        // On a tie the port that was not served last goes first.
        if (req[1] && (!req[0] || last == GNT_CPU)) gnt = GNT_EXT;
`endif
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency memory between the CPU control path and an external port, one access at a time.
// Build option: MEMARB_CPU_PRIO_EN gives the CPU fixed priority (default is round-robin).
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    grant_t           gnt_q;
    grant_t           last_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [DW-1:0]    mem_wdata_q;
    logic [DW-1:0]    cpu_rdata_q;
    logic [DW-1:0]    ext_rdata_q;
    logic             cpu_ready_q;
    logic             ext_ready_q;

    grant_t           pick_d;
    logic             sel_we_d;
    logic [AW-1:0]    sel_addr_d;
    logic [DW-1:0]    sel_wdata_d;

    rr_arbiter2 u_arb (
        .req  ({ext_req, cpu_req}),
        .last (last_q),
        .gnt  (pick_d)
    );

    assign sel_we_d    = (pick_d == GNT_EXT) ? ext_we    : cpu_we;
    assign sel_addr_d  = (pick_d == GNT_EXT) ? ext_addr  : cpu_addr;
    assign sel_wdata_d = (pick_d == GNT_EXT) ? ext_wdata : cpu_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= GNT_CPU;
            last_q      <= GNT_EXT;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            ext_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req || ext_req) begin
                        gnt_q       <= pick_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        cnt_q       <= CNT_W'(MEM_LAT);
                        state_q     <= ISSUE;
                    end
                end
                // ISSUE and WAIT together span MEM_LAT cycles; the strobe lives only in ISSUE.
                ISSUE, WAIT: begin
                    mem_en_q <= 1'b0;
                    cnt_q    <= cnt_q - 1'b1;
                    state_q  <= (cnt_q == CNT_W'(1)) ? CAPT : WAIT;
                end
                CAPT: begin
                    if (gnt_q == GNT_CPU) begin
                        if (!mem_we_q) cpu_rdata_q <= mem_rdata;
                        cpu_ready_q <= 1'b1;
                    end else begin
                        if (!mem_we_q) ext_rdata_q <= mem_rdata;
                        ext_ready_q <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    cpu_ready_q <= 1'b0;
                    ext_ready_q <= 1'b0;
                    last_q      <= gnt_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign ext_rdata = ext_rdata_q;
    assign ext_ready = ext_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed table, random traffic against a transaction model,
// MEM_LAT=3 sweep and reset-during-access on a second instance.
module tb_unified_mem_arbiter;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT=1 instance
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, ext_ready, mem_en, mem_we;

    // MEM_LAT=3 instance, CPU port only
    logic        reset3 = 1'b1;
    logic        c3_req = 0;
    logic [31:0] c3_addr = 0;
    logic [31:0] c3_rdata, e3_rdata, m3_addr, m3_wdata, m3_rdata;
    logic        c3_ready, e3_ready, m3_en, m3_we;

    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ready(ext_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT3)) dut3 (
        .clk(clk), .reset(reset3),
        .cpu_req(c3_req), .cpu_we(1'b0), .cpu_addr(c3_addr), .cpu_wdata(32'h0),
        .cpu_rdata(c3_rdata), .cpu_ready(c3_ready),
        .ext_req(1'b0), .ext_we(1'b0), .ext_addr(32'h0), .ext_wdata(32'h0),
        .ext_rdata(e3_rdata), .ext_ready(e3_ready),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_rdata(m3_rdata)
    );

    // Memory device: 1024 words, data valid exactly MEM_LAT cycles after the strobe, garbage otherwise.
    function automatic logic [31:0] init_word(int i);
        if (i == 16) return 32'h8C02_0004;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    bit   [31:0] mem [0:1023];
    bit          wv  [0:1023];
    logic [31:0] rd1 = 32'hBAD0_0001;
    logic [31:0] p3  [0:2];

    function automatic logic [31:0] env_rd(logic [31:0] a);
        return wv[a[11:2]] ? mem[a[11:2]] : init_word(int'(a[11:2]));
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            wv[mem_addr[11:2]]  <= 1'b1;
        end
        rd1   <= (mem_en && !mem_we) ? env_rd(mem_addr) : 32'hBAD0_0001;
        p3[0] <= m3_en ? env_rd(m3_addr) : 32'hBAD0_0003;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata = rd1;
    assign m3_rdata  = p3[2];

    // Reference model state
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_crd = 0, exp_erd = 0;
    logic        last_was_ext = 1'b1;

    function automatic logic pick_cpu(logic c, logic e, logic last_ext);
`ifdef MEMARB_CPU_PRIO_EN
        return c;
`else
        if (c && e) return last_ext;
        return c;
`endif
    endfunction

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic creq, cwe, input logic [31:0] caddr, cwd,
                         input logic ereq, ewe, input logic [31:0] eaddr, ewd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        ext_req = ereq; ext_we = ewe; ext_addr = eaddr; ext_wdata = ewd;
    endtask

    // Watch one access on the MEM_LAT=1 instance; ready is expected on the k-th falling edge.
    task automatic observe(input logic exp_cpu, input logic [31:0] exp_rd, input int k,
                           input int raise_ext_at, input string tag);
        int          got = 0;
        int          pulses = 0;
        logic        saw_c = 0, saw_e = 0;
        logic        gwe   = exp_cpu ? cpu_we    : ext_we;
        logic [31:0] gaddr = exp_cpu ? cpu_addr  : ext_addr;
        logic [31:0] gwd   = exp_cpu ? cpu_wdata : ext_wdata;
        for (int i = 1; i <= k + 6 && got == 0; i++) begin
            @(negedge clk);
            if (mem_en) begin
                pulses++;
                chk({tag, " mem_addr"}, mem_addr, gaddr);
                chk({tag, " mem_we"}, 32'(mem_we), 32'(gwe));
                if (gwe) chk({tag, " mem_wdata"}, mem_wdata, gwd);
            end
            if (cpu_ready || ext_ready) begin
                got = i; saw_c = cpu_ready; saw_e = ext_ready;
            end
            if (i == raise_ext_at) ext_req = 1'b1;
        end
        chk({tag, " latency"}, 32'(got), 32'(k));
        chk({tag, " ready port"}, 32'({saw_c, saw_e}), exp_cpu ? 32'd2 : 32'd1);
        chk({tag, " mem_en count"}, 32'(pulses), 32'd1);
        if (!gwe) begin
            if (exp_cpu) exp_crd = exp_rd;
            else         exp_erd = exp_rd;
        end else begin
            ref_mem[gaddr[11:2]] = gwd;
        end
        chk({tag, " cpu_rdata"}, cpu_rdata, exp_crd);
        chk({tag, " ext_rdata"}, ext_rdata, exp_erd);
        last_was_ext = !exp_cpu;
    endtask

    // One CPU read on the MEM_LAT=3 instance.
    task automatic rd3(input logic [31:0] a, input int k, input string tag);
        int got = 0;
        int pulses = 0;
        logic saw_e = 0;
        c3_addr = a; c3_req = 1'b1;
        for (int i = 1; i <= k + 6 && got == 0; i++) begin
            @(negedge clk);
            if (m3_en) begin
                pulses++;
                chk({tag, " mem_addr"}, m3_addr, a);
            end
            if (e3_ready) saw_e = 1'b1;
            if (c3_ready) got = i;
        end
        c3_req = 1'b0;
        chk({tag, " latency"}, 32'(got), 32'(k));
        chk({tag, " mem_en count"}, 32'(pulses), 32'd1);
        chk({tag, " rdata"}, c3_rdata, ref_mem[a[11:2]]);
        chk({tag, " ext_ready quiet"}, 32'(saw_e), 32'd0);
    endtask

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        ereq, ewe;
        logic [31:0] eaddr, ewd;
        logic        exp_cpu;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic        v, we;
        logic [31:0] a, d;
    } rq_t;

    function automatic rq_t new_rq();
        rq_t r;
        r.v  = 1'b1;
        r.we = ($urandom_range(0, 2) == 0);
        r.a  = 32'h100 + 32'(4 * $urandom_range(0, 15));
        r.d  = $urandom;
        return r;
    endfunction

`ifdef MEMARB_CPU_PRIO_EN
    localparam logic [3:0] TIE_EXP = 4'b1111;
`else
    localparam logic [3:0] TIE_EXP = 4'b0101;
`endif

    vec_t tbl [0:8];

    initial begin
        rq_t  pc, pe, w;
        logic ec;
        int   rise;

        for (int i = 0; i < 4; i++)
            tbl[i] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0,
                       TIE_EXP[i], TIE_EXP[i] ? 32'h8C02_0004 : init_word(32)};
        tbl[4] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h80, 32'h0,         1'b0, init_word(32)};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[7] = '{1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 32'h1234_5678};

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        pc = '{1'b0, 1'b0, 32'h0, 32'h0};
        pe = '{1'b0, 1'b0, 32'h0, 32'h0};

        repeat (3) @(negedge clk);
        chk("reset ctl", 32'({cpu_ready, ext_ready, mem_en, mem_we}), 32'd0);
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        chk("reset ext_rdata", ext_rdata, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        reset3 = 1'b0;

        // Directed table: tie sequence, external write then CPU read-back, write leaves rdata alone.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd,
                  tbl[i].ereq, tbl[i].ewe, tbl[i].eaddr, tbl[i].ewd);
            observe(tbl[i].exp_cpu, tbl[i].exp_rd, (i == 0) ? LAT1 + 2 : LAT1 + 3, 0, "tbl");
        end

        // Random traffic; a losing requester keeps its request unchanged until served.
        for (int r = 0; r < 40; r++) begin
            if (!pc.v && $urandom_range(0, 3) != 0) pc = new_rq();
            if (!pe.v && $urandom_range(0, 3) != 0) pe = new_rq();
            if (!pc.v && !pe.v) pc = new_rq();
            drive(pc.v, pc.we, pc.a, pc.d, pe.v, pe.we, pe.a, pe.d);
            ec = pick_cpu(pc.v, pe.v, last_was_ext);
            w  = ec ? pc : pe;
            observe(ec, w.we ? 32'h0 : ref_mem[w.a[11:2]], LAT1 + 3, 0, "rand");
            if (ec) pc.v = 1'b0;
            else    pe.v = 1'b0;
        end

        // CPU write with the external request arriving mid-access.
        drive(1'b1, 1'b1, 32'h30, 32'hCAFE_0001, 1'b0, 1'b0, 32'h30, 32'h0);
        rise = 2;
        observe(1'b1, 32'h0, LAT1 + 3, rise, "midreq cpu");
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
        observe(1'b0, 32'hCAFE_0001, LAT1 + 3, 0, "midreq ext");
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // MEM_LAT=3 read sweep.
        rd3(32'h40, LAT3 + 2, "lat3 first");
        for (int r = 0; r < 6; r++)
            rd3(32'(4 * $urandom_range(0, 255)), LAT3 + 3, "lat3 sweep");

        // Reset while the access sits in WAIT.
        c3_addr = 32'h44; c3_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset3 = 1'b1;
        #1;
        chk("rst3 ctl", 32'({c3_ready, e3_ready, m3_en, m3_we}), 32'd0);
        chk("rst3 cpu_rdata", c3_rdata, 32'h0);
        chk("rst3 ext_rdata", e3_rdata, 32'h0);
        chk("rst3 mem_addr", m3_addr, 32'h0);
        chk("rst3 mem_wdata", m3_wdata, 32'h0);
        c3_req = 1'b0;
        repeat (2) @(negedge clk);
        reset3 = 1'b0;
        begin
            int stray = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (c3_ready || e3_ready || m3_en) stray++;
            end
            chk("rst3 no stray activity", 32'(stray), 32'd0);
        end
        rd3(32'h48, LAT3 + 2, "rst3 recover");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
